// File: rtl/proc_pkg.sv
// Shared types for the memory arbiter: FSM states, grant encoding and the bus command word.
// Combinational content only. There is no latency or backpressure.
package proc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side (fetch/data) and memory-side signals of the arbiter, bundled as one interface.
// slave = arbiter view, master = processor/memory view. Flow control is req/valid, with one transaction outstanding.
interface mem_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_adr;
    logic [31:0] instr_read;
    logic        instr_valid;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_adr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [31:0] data_rdata;
    logic        data_valid;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        bus_err;

    modport slave (
        input  instr_req, instr_adr, data_req, data_we, data_adr, data_wdata, data_be,
               mem_rdata, mem_valid,
        output instr_read, instr_valid, data_rdata, data_valid,
               mem_req, mem_we, mem_adr, mem_wdata, mem_be, bus_err
    );

    modport master (
        output instr_req, instr_adr, data_req, data_we, data_adr, data_wdata, data_be,
               mem_rdata, mem_valid,
        input  instr_read, instr_valid, data_rdata, data_valid,
               mem_req, mem_we, mem_adr, mem_wdata, mem_be, bus_err
    );
endinterface

// File: rtl/arb_timer.sv
// Bus-phase watchdog: counts cycles while enabled and flags when the count reaches TIMEOUT-1.
// The expired flag is combinational from the count. Clear takes priority over enable, with no backpressure.
module arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RES,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and data ports; MEM_ARB_RR_EN selects round-robin, else data has fixed priority.
// Latency: mem_req 1 cycle after the grant, client valid in the mem_valid/timeout cycle. Clients hold req until their valid.
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RES,
    mem_arbiter_if.slave  bus
);
    arb_state_t state_q, state_d;
    logic       mem_req_q, mem_req_d;
    mem_cmd_t   cmd_q, cmd_d;
    arb_gnt_t   gnt;
    logic       bus_active;
    logic       done;
    logic       expired;
    logic       timer_clr;
`ifdef MEM_ARB_RR_EN
    arb_gnt_t   last_gnt_q, last_gnt_d;
`endif

    assign bus_active = (state_q != ARB_IDLE);
    assign done       = bus_active && (bus.mem_valid || expired);
    assign timer_clr  = !bus_active || done;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK     (CLK),
        .RES     (RES),
        .clr     (timer_clr),
        .en      (bus_active),
        .expired (expired)
    );

    // On a tie, round-robin picks the port that did not win last time.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        gnt = (bus.data_req && (!bus.instr_req || last_gnt_q == GNT_I)) ? GNT_D : GNT_I;
`else
        gnt = bus.data_req ? GNT_D : GNT_I;
`endif
    end

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        cmd_d     = cmd_q;
`ifdef MEM_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (bus.instr_req || bus.data_req) begin
                    mem_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_gnt_d = gnt;
`endif
                    if (gnt == GNT_D) begin
                        state_d = ARB_BUS_D;
                        cmd_d   = '{we: bus.data_we, adr: bus.data_adr,
                                    wdata: bus.data_wdata, be: bus.data_be};
                    end else begin
                        state_d = ARB_BUS_I;
                        cmd_d   = '{we: 1'b0, adr: bus.instr_adr,
                                    wdata: 32'h0, be: MEM_BE_ALL};
                    end
                end
            end
            ARB_BUS_I, ARB_BUS_D: begin
                if (done) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q   <= ARB_IDLE;
            mem_req_q <= 1'b0;
            cmd_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= GNT_I;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            cmd_q     <= cmd_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Completions are suppressed while RES is high so an abandoned transaction never pulses.
    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr_read  = '0;
        bus.data_valid  = 1'b0;
        bus.data_rdata  = '0;
        bus.bus_err     = 1'b0;
        if (!RES && done) begin
            bus.bus_err = !bus.mem_valid;
            if (state_q == ARB_BUS_I) begin
                bus.instr_valid = 1'b1;
                bus.instr_read  = bus.mem_valid ? bus.mem_rdata : 32'h0;
            end else begin
                bus.data_valid  = 1'b1;
                bus.data_rdata  = bus.mem_valid ? bus.mem_rdata : 32'h0;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_adr   = cmd_q.adr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.mem_be    = cmd_q.be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4, covering fetch, store, ties, timeout, timeout race and reset mid-op.
// Inputs change 1 ns after the rising edge, and outputs are sampled on the falling edge.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RES;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus_if();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus_if.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        bus_if.instr_req  = 1'b0;
        bus_if.instr_adr  = 32'h0;
        bus_if.data_req   = 1'b0;
        bus_if.data_we    = 1'b0;
        bus_if.data_adr   = 32'h0;
        bus_if.data_wdata = 32'h0;
        bus_if.data_be    = 4'h0;
        bus_if.mem_rdata  = 32'h0;
        bus_if.mem_valid  = 1'b0;
    endtask

    task automatic test_reset();
        RES = 1'b1;
        clear_inputs();
        tick();
        tick();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be} !== 70'h0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got req=%b we=%b adr=%h wdata=%h be=%h, expected all 0",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be);
        end
        checks++;
        if ({bus_if.instr_valid, bus_if.data_valid, bus_if.bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got iv=%b dv=%b err=%b, expected 000",
                     bus_if.instr_valid, bus_if.data_valid, bus_if.bus_err);
        end
        tick();
        RES = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        bus_if.instr_req = 1'b1;
        bus_if.instr_adr = 32'h100;
        smp();
        checks++;
        if (bus_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req_before_grant: got %b, expected 0", bus_if.mem_req);
        end
        tick();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_adr, bus_if.mem_be, bus_if.mem_we} !== {1'b1, 32'h100, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL fetch_mem_cmd: got req=%b adr=%h be=%h we=%b, expected 1/00000100/f/0",
                     bus_if.mem_req, bus_if.mem_adr, bus_if.mem_be, bus_if.mem_we);
        end
        checks++;
        if (bus_if.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_valid: got %b, expected 0", bus_if.instr_valid);
        end
        tick();
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 32'h00500093;
        smp();
        checks++;
        if ({bus_if.instr_valid, bus_if.instr_read, bus_if.data_valid} !== {1'b1, 32'h00500093, 1'b0}) begin
            errors++;
            $display("FAIL fetch_valid: got iv=%b read=%h dv=%b, expected 1/00500093/0",
                     bus_if.instr_valid, bus_if.instr_read, bus_if.data_valid);
        end
        tick();
        clear_inputs();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after: got req=%b iv=%b, expected 00", bus_if.mem_req, bus_if.instr_valid);
        end
    endtask

    task automatic test_store();
        tick();
        bus_if.data_req   = 1'b1;
        bus_if.data_we    = 1'b1;
        bus_if.data_adr   = 32'h2000;
        bus_if.data_wdata = 32'hDEADBEEF;
        bus_if.data_be    = 4'h3;
        tick();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be} !==
            {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3}) begin
            errors++;
            $display("FAIL store_mem_cmd: got req=%b we=%b adr=%h wdata=%h be=%h, expected 1/1/00002000/deadbeef/3",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be);
        end
        bus_if.data_adr = 32'h3000;
        tick();
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 32'h0;
        smp();
        checks++;
        if ({bus_if.data_valid, bus_if.data_rdata, bus_if.instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_valid: got dv=%b rdata=%h iv=%b, expected 1/00000000/0",
                     bus_if.data_valid, bus_if.data_rdata, bus_if.instr_valid);
        end
        checks++;
        if (bus_if.mem_adr !== 32'h2000) begin
            errors++;
            $display("FAIL store_adr_stable: got %h, expected 00002000", bus_if.mem_adr);
        end
        tick();
        clear_inputs();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL store_after: got req=%b dv=%b, expected 00", bus_if.mem_req, bus_if.data_valid);
        end
    endtask

    task automatic test_tie();
        logic exp_d [3];
`ifdef MEM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        RES = 1'b1;
        clear_inputs();
        tick();
        tick();
        RES = 1'b0;
        bus_if.instr_req = 1'b1;
        bus_if.instr_adr = 32'h400;
        bus_if.data_req  = 1'b1;
        bus_if.data_adr  = 32'h800;
        bus_if.data_be   = 4'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            smp();
            checks++;
            if ({bus_if.mem_req, bus_if.mem_adr} !== {1'b1, (exp_d[i] ? 32'h800 : 32'h400)}) begin
                errors++;
                $display("FAIL tie_grant_%0d: got req=%b adr=%h, expected req=1 adr=%h",
                         i, bus_if.mem_req, bus_if.mem_adr, (exp_d[i] ? 32'h800 : 32'h400));
            end
            tick();
            bus_if.mem_valid = 1'b1;
            bus_if.mem_rdata = 32'h10 + 32'(i);
            smp();
            checks++;
            if ({bus_if.data_valid, bus_if.instr_valid} !== {exp_d[i], ~exp_d[i]}) begin
                errors++;
                $display("FAIL tie_valid_%0d: got dv=%b iv=%b, expected dv=%b iv=%b",
                         i, bus_if.data_valid, bus_if.instr_valid, exp_d[i], ~exp_d[i]);
            end
            tick();
            bus_if.mem_valid = 1'b0;
            smp();
            checks++;
            if (bus_if.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL tie_idle_gap_%0d: got req=%b, expected 0", i, bus_if.mem_req);
            end
        end
        bus_if.data_req = 1'b0;
        tick();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_adr} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL tie_fetch_after_drop: got req=%b adr=%h, expected 1/00000400",
                     bus_if.mem_req, bus_if.mem_adr);
        end
        tick();
        bus_if.mem_valid = 1'b1;
        smp();
        tick();
        clear_inputs();
        smp();
    endtask

    task automatic test_timeout();
        tick();
        bus_if.instr_req = 1'b1;
        bus_if.instr_adr = 32'h40;
        bus_if.mem_rdata = 32'hFFFFFFFF;
        tick();
        for (int k = 1; k <= 4; k++) begin
            smp();
            if (k < 4) begin
                checks++;
                if ({bus_if.instr_valid, bus_if.bus_err} !== 2'b00) begin
                    errors++;
                    $display("FAIL timeout_early_c%0d: got iv=%b err=%b, expected 00",
                             k, bus_if.instr_valid, bus_if.bus_err);
                end
                tick();
            end else begin
                checks++;
                if ({bus_if.instr_valid, bus_if.bus_err, bus_if.instr_read} !== {1'b1, 1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL timeout_expire: got iv=%b err=%b read=%h, expected 1/1/00000000",
                             bus_if.instr_valid, bus_if.bus_err, bus_if.instr_read);
                end
            end
        end
        tick();
        clear_inputs();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.bus_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_after: got req=%b err=%b, expected 00", bus_if.mem_req, bus_if.bus_err);
        end
    endtask

    task automatic test_timeout_race();
        tick();
        bus_if.data_req = 1'b1;
        bus_if.data_adr = 32'h80;
        bus_if.data_be  = 4'hF;
        tick();
        for (int k = 1; k < 4; k++) begin
            smp();
            tick();
        end
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 32'hCAFEF00D;
        smp();
        checks++;
        if ({bus_if.data_valid, bus_if.data_rdata, bus_if.bus_err} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
            errors++;
            $display("FAIL race_completion: got dv=%b rdata=%h err=%b, expected 1/cafef00d/0",
                     bus_if.data_valid, bus_if.data_rdata, bus_if.bus_err);
        end
        tick();
        clear_inputs();
        smp();
        checks++;
        if (bus_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL race_after: got req=%b, expected 0", bus_if.mem_req);
        end
    endtask

    task automatic test_reset_mid_op();
        tick();
        bus_if.data_req   = 1'b1;
        bus_if.data_we    = 1'b1;
        bus_if.data_adr   = 32'h44;
        bus_if.data_wdata = 32'h55;
        bus_if.data_be    = 4'hF;
        tick();
        smp();
        checks++;
        if (bus_if.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_granted: got req=%b, expected 1", bus_if.mem_req);
        end
        RES = 1'b1;
        tick();
        RES = 1'b0;
        clear_inputs();
        smp();
        checks++;
        if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be, bus_if.data_valid} !== 71'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got req=%b we=%b adr=%h wdata=%h be=%h dv=%b, expected all 0",
                     bus_if.mem_req, bus_if.mem_we, bus_if.mem_adr, bus_if.mem_wdata, bus_if.mem_be, bus_if.data_valid);
        end
        tick();
        bus_if.mem_valid = 1'b1;
        bus_if.mem_rdata = 32'h99;
        smp();
        checks++;
        if ({bus_if.data_valid, bus_if.instr_valid, bus_if.data_rdata, bus_if.bus_err} !== 35'h0) begin
            errors++;
            $display("FAIL midrst_late_valid: got dv=%b iv=%b rdata=%h err=%b, expected all 0",
                     bus_if.data_valid, bus_if.instr_valid, bus_if.data_rdata, bus_if.bus_err);
        end
        tick();
        bus_if.mem_valid = 1'b0;
        smp();
        checks++;
        if (bus_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got req=%b, expected 0", bus_if.mem_req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_timeout();
        test_timeout_race();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
